// File: rtl/object_motion_pkg.sv
// Shared game constants and the object FSM state encoding.
package object_motion_pkg;

    // Visible window size in pixels
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Default physics: gravity adds to vy once per frame, vy saturates at VY_MAX
    localparam int DEFAULT_GRAVITY = 1;
    localparam int DEFAULT_VY_MAX  = 15;

    // Objects start on the bottom row of the window
    localparam int DEFAULT_LAUNCH_Y = SCREEN_H - 1;

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } state_t;

endpackage

// File: rtl/object_motion_integrator.sv
// Velocity/position integrator: loads launch values, steps one frame on request,
// wraps positions to their register width and saturates vy at +VY_MAX.
module motion_integrator
    import object_motion_pkg::*;
#(
    parameter int GRAVITY  = DEFAULT_GRAVITY,
    parameter int VY_MAX   = DEFAULT_VY_MAX,
    parameter int LAUNCH_Y = DEFAULT_LAUNCH_Y
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [9:0]        load_x,
    input  logic signed [5:0] load_vx,
    input  logic signed [6:0] load_vy,
    output logic [9:0]        posx,
    output logic [8:0]        posy,
    output logic signed [6:0] vy
);

    localparam logic signed [8:0] GRAVITY_S = 9'(GRAVITY);
    localparam logic signed [8:0] VY_MAX_S  = 9'(VY_MAX);

    logic [9:0]        posx_reg, posx_next;
    logic [8:0]        posy_reg, posy_next;
    logic signed [5:0] vx_reg;
    logic signed [6:0] vy_reg, vy_next;
    logic signed [8:0] vy_sum;

    // Next-frame values: sign-extended velocity added with natural wrap,
    // gravity added in a wider width so the saturation compare cannot overflow
    always_comb begin
        posx_next = posx_reg + {{4{vx_reg[5]}}, vx_reg};
        posy_next = posy_reg + {{2{vy_reg[6]}}, vy_reg};
        vy_sum    = $signed({{2{vy_reg[6]}}, vy_reg}) + GRAVITY_S;
        vy_next   = (vy_sum > VY_MAX_S) ? VY_MAX_S[6:0] : vy_sum[6:0];
    end

    // Motion state: reset clears, load starts a flight, step advances one frame
    always_ff @(posedge clk) begin
        if (rst) begin
            posx_reg <= '0;
            posy_reg <= '0;
            vx_reg   <= '0;
            vy_reg   <= '0;
        end else if (load) begin
            posx_reg <= load_x;
            posy_reg <= 9'(LAUNCH_Y);
            vx_reg   <= load_vx;
            vy_reg   <= load_vy;
        end else if (step) begin
            posx_reg <= posx_next;
            posy_reg <= posy_next;
            vy_reg   <= vy_next;
        end
    end

    assign posx = posx_reg;
    assign posy = posy_reg;
    assign vy   = vy_reg;

endmodule

// File: rtl/object_motion.sv
// Flying-object controller: IDLE/FLY state machine, frame counter and the
// exit pulses (missed, timeout); motion itself lives in motion_integrator.
module object_motion
    import object_motion_pkg::*;
#(
    parameter int GRAVITY    = DEFAULT_GRAVITY,
    parameter int VY_MAX     = DEFAULT_VY_MAX,
    parameter int LAUNCH_Y   = DEFAULT_LAUNCH_Y,
    parameter int MAX_FRAMES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              launch,
    input  logic [9:0]        launch_x,
    input  logic signed [5:0] launch_vx,
    input  logic signed [6:0] launch_vy,
    input  logic              sliced,
    input  logic              out_of_bound,
    output logic [9:0]        posx,
    output logic [8:0]        posy,
    output logic              active,
    output logic              missed,
    output logic              timeout
);

    localparam int CNT_W = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES + 1);
    // Timeout fires on the tick that brings the count up to MAX_FRAMES
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAMES - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;
    logic              active_reg, missed_reg, timeout_reg;
    logic signed [6:0] vy;
    logic              load, step, oob_honoured, cnt_expire;

    // Control decode; a slice suppresses the frame update, and the bound flag
    // only counts once the object is falling (it starts below the window)
    always_comb begin
        load         = (state_reg == IDLE) && launch;
        step         = (state_reg == FLY) && frame_tick && !sliced;
        oob_honoured = (state_reg == FLY) && out_of_bound && !vy[6];
        cnt_expire   = step && (frame_cnt_reg == CNT_LAST);
    end

    motion_integrator #(
        .GRAVITY  (GRAVITY),
        .VY_MAX   (VY_MAX),
        .LAUNCH_Y (LAUNCH_Y)
    ) u_integrator (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .load_x  (launch_x),
        .load_vx (launch_vx),
        .load_vy (launch_vy),
        .posx    (posx),
        .posy    (posy),
        .vy      (vy)
    );

    // Flight FSM with registered outputs; exit priority is slice, miss, timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            frame_cnt_reg <= '0;
            active_reg    <= 1'b0;
            missed_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            missed_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        state_reg     <= FLY;
                        frame_cnt_reg <= '0;
                        active_reg    <= 1'b1;
                    end
                end
                FLY: begin
                    if (step) begin
                        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                    end
                    if (sliced) begin
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                    end else if (oob_honoured) begin
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                        missed_reg <= 1'b1;
                    end else if (cnt_expire) begin
                        state_reg   <= IDLE;
                        active_reg  <= 1'b0;
                        timeout_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign active  = active_reg;
    assign missed  = missed_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_object_motion.sv
// Bench for object_motion: directed vector table, hand sequences for the apex,
// timeout and saturation cases, then random stimulus against a reference model.
module tb_object_motion;

    localparam int G     = 1;
    localparam int VYMAX = 15;
    localparam int LY    = 479;
    localparam int MAXF  = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_tick = 1'b0;
    logic              launch = 1'b0;
    logic [9:0]        launch_x = '0;
    logic signed [5:0] launch_vx = '0;
    logic signed [6:0] launch_vy = '0;
    logic              sliced = 1'b0;
    logic              out_of_bound = 1'b0;
    logic [9:0]        posx, posx2;
    logic [8:0]        posy, posy2;
    logic              active, active2, missed, missed2, timeout, timeout2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    object_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
        .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .sliced(sliced), .out_of_bound(out_of_bound),
        .posx(posx), .posy(posy), .active(active), .missed(missed), .timeout(timeout)
    );

    object_motion #(.MAX_FRAMES(8)) dut8 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
        .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .sliced(sliced), .out_of_bound(out_of_bound),
        .posx(posx2), .posy(posy2), .active(active2), .missed(missed2), .timeout(timeout2)
    );

    // Reference model of the default-parameter instance, in plain integers
    bit m_fly, m_missed, m_timeout;
    int m_x, m_y, m_vx, m_vy, m_cnt;

    function automatic int wrap(int a, int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic model_step();
        bit honour;
        honour = out_of_bound && (m_vy >= 0);
        if (rst) begin
            m_fly = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_cnt = 0;
            m_missed = 0; m_timeout = 0;
        end else if (!m_fly) begin
            m_missed = 0; m_timeout = 0;
            if (launch) begin
                m_fly = 1; m_x = int'(launch_x); m_y = LY;
                m_vx = launch_vx; m_vy = launch_vy; m_cnt = 0;
            end
        end else begin
            m_missed = 0; m_timeout = 0;
            if (sliced) begin
                m_fly = 0;
            end else begin
                if (frame_tick) begin
                    m_x  = wrap(m_x + m_vx, 1024);
                    m_y  = wrap(m_y + m_vy, 512);
                    m_vy = (m_vy + G > VYMAX) ? VYMAX : m_vy + G;
                    m_cnt++;
                end
                if (honour) begin
                    m_fly = 0; m_missed = 1;
                end else if (frame_tick && m_cnt >= MAXF) begin
                    m_fly = 0; m_timeout = 1;
                end
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic apply(bit r, bit l, int lx, int lvx, int lvy, bit t, bit s, bit o);
        rst = r; launch = l; launch_x = 10'(lx); launch_vx = 6'(lvx); launch_vy = 7'(lvy);
        frame_tick = t; sliced = s; out_of_bound = o;
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit    r, l;
        int    lx, lvx, lvy;
        bit    t, s, o;
        int    ex, ey;
        bit    ea, em, et;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit l, int lx, int lvx, int lvy, bit t, bit s, bit o,
                                int ex, int ey, bit ea, bit em, bit et, string name);
        vec_t v;
        v.r = r; v.l = l; v.lx = lx; v.lvx = lvx; v.lvy = lvy; v.t = t; v.s = s; v.o = o;
        v.ex = ex; v.ey = ey; v.ea = ea; v.em = em; v.et = et; v.name = name;
        return v;
    endfunction

    initial begin
        // rst launch  x  vx  vy tick sl oob | posx posy act mis to
        vecs.push_back(mk(1,0,  0,  0,  0, 0,0,0,    0,  0,0,0,0, "reset"));
        vecs.push_back(mk(0,1,100,  3,-12, 0,0,0,  100,479,1,0,0, "launch_load"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,  103,467,1,0,0, "first_tick"));
        vecs.push_back(mk(0,1,  5,  1,  1, 0,0,0,  103,467,1,0,0, "launch_ignored_in_fly"));
        vecs.push_back(mk(0,0,  0,  0,  0, 0,1,0,  103,467,0,0,0, "sliced_exit"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,  103,467,0,0,0, "idle_tick_holds"));
        vecs.push_back(mk(0,1,  2, -3, -5, 0,0,0,    2,479,1,0,0, "launch_left_edge"));
        vecs.push_back(mk(0,0,  0,  0,  0, 0,0,1,    2,479,1,0,0, "oob_rising_ignored"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0, 1023,474,1,0,0, "posx_wrap"));
        vecs.push_back(mk(0,0,  0,  0,  0, 0,1,0, 1023,474,0,0,0, "sliced_exit2"));
        vecs.push_back(mk(0,1, 50,  0,  4, 0,0,0,   50,479,1,0,0, "launch_falling"));
        vecs.push_back(mk(0,0,  0,  0,  0, 0,0,1,   50,479,0,1,0, "oob_falling_missed"));
        vecs.push_back(mk(0,0,  0,  0,  0, 0,0,0,   50,479,0,0,0, "missed_one_cycle"));
        vecs.push_back(mk(0,1,200,  2,  1, 0,0,0,  200,479,1,0,0, "launch_slow"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,1,1,  200,479,0,0,0, "slice_beats_oob_and_tick"));
        vecs.push_back(mk(0,1,300, -1,-10, 0,0,0,  300,479,1,0,0, "launch_mid"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,  299,469,1,0,0, "mid_tick"));
        vecs.push_back(mk(1,1,  7,  1,  1, 1,1,1,    0,  0,0,0,0, "rst_mid_flight"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,    0,  0,0,0,0, "post_rst_idle"));
        vecs.push_back(mk(0,1,  0,  0, 14, 0,0,0,    0,479,1,0,0, "launch_vy14"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,    0,493,1,0,0, "vy14_tick"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,    0,508,1,0,0, "vy15_tick"));
        vecs.push_back(mk(0,0,  0,  0,  0, 1,0,0,    0, 11,1,0,0, "vy_saturated_wrap"));
        vecs.push_back(mk(0,0,  0,  0,  0, 0,1,0,    0, 11,0,0,0, "final_slice"));

        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].l, vecs[i].lx, vecs[i].lvx, vecs[i].lvy,
                  vecs[i].t, vecs[i].s, vecs[i].o);
            $display("vec %0d %s: posx=%0d posy=%0d active=%0b missed=%0b timeout=%0b",
                     i, vecs[i].name, posx, posy, active, missed, timeout);
            check({vecs[i].name, ".posx"},    int'(posx),    vecs[i].ex);
            check({vecs[i].name, ".posy"},    int'(posy),    vecs[i].ey);
            check({vecs[i].name, ".active"},  int'(active),  int'(vecs[i].ea));
            check({vecs[i].name, ".missed"},  int'(missed),  int'(vecs[i].em));
            check({vecs[i].name, ".timeout"}, int'(timeout), int'(vecs[i].et));
        end

        // Apex and descent: 12 ticks up to the apex, 12 more back down
        apply(1,0,0,0,0,0,0,0);
        apply(0,1,100,3,-12,0,0,0);
        repeat (12) apply(0,0,0,0,0,1,0,0);
        $display("apex: posy=%0d vy=%0d active=%0b", posy, dut.vy, active);
        check("apex.posy",   int'(posy),   401);
        check("apex.vy",     int'(dut.vy), 0);
        check("apex.active", int'(active), 1);
        repeat (12) apply(0,0,0,0,0,1,0,0);
        $display("descent: posy=%0d vy=%0d", posy, dut.vy);
        check("descent.posy", int'(posy),   467);
        check("descent.vy",   int'(dut.vy), 12);

        // Timeout on the MAX_FRAMES=8 instance, rising the whole time
        apply(1,0,0,0,0,0,0,0);
        apply(0,1,0,0,-40,0,0,0);
        for (int k = 1; k <= 8; k++) begin
            apply(0,0,0,0,0,1,0,0);
            $display("timeout tick %0d: active=%0b timeout=%0b missed=%0b", k, active2, timeout2, missed2);
            check($sformatf("to_tick%0d.timeout", k), int'(timeout2), (k == 8) ? 1 : 0);
            check($sformatf("to_tick%0d.active", k),  int'(active2),  (k == 8) ? 0 : 1);
            check($sformatf("to_tick%0d.missed", k),  int'(missed2),  0);
        end
        apply(0,0,0,0,0,1,0,0);
        $display("timeout after: active=%0b timeout=%0b", active2, timeout2);
        check("to_after.timeout", int'(timeout2), 0);
        check("to_after.active",  int'(active2),  0);

        // Random stimulus against the model
        apply(1,0,0,0,0,0,0,0);
        for (int n = 0; n < 2500; n++) begin
            bit r, l, t, s, o;
            int lx, lvx, lvy;
            r   = ($urandom_range(0, 199) == 0);
            l   = ($urandom_range(0, 5) == 0);
            t   = ($urandom_range(0, 1) == 0);
            s   = ($urandom_range(0, 49) == 0);
            o   = ($urandom_range(0, 7) == 0);
            lx  = $urandom_range(0, 1023);
            lvx = $urandom_range(0, 63) - 32;
            lvy = $urandom_range(0, 127) - 64;
            if (!r && l && !m_fly)
                $display("random launch @%0d: x=%0d vx=%0d vy=%0d", n, lx, lvx, lvy);
            apply(r, l, lx, lvx, lvy, t, s, o);
            check($sformatf("rand%0d.outputs", n),
                  {int'(posx), int'(posy), int'(active), int'(missed), int'(timeout)} == {m_x, m_y, int'(m_fly), int'(m_missed), int'(m_timeout)} ? 1 : 0, 1);
            check($sformatf("rand%0d.vy", n), int'(dut.vy), m_vy);
            if (missed && timeout) check($sformatf("rand%0d.miss_and_timeout", n), 1, 0);
            if (n_bad > 20) break;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/object_motion.md
OBJECT_MOTION -- requirements
Module: object_motion

Interface
REQ-001 The module SHALL have parameter GRAVITY, default 1, meaning the vy increment per frame in px/frame².
REQ-002 The module SHALL have parameter VY_MAX, default 15, meaning the maximum downward speed (vy saturation).
REQ-003 The module SHALL have parameter LAUNCH_Y, default 479, meaning the posy loaded on launch.
REQ-004 The module SHALL have parameter MAX_FRAMES, default 255, meaning the flight timeout in frames.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-008 The module SHALL have port launch, input, 1 bit: request to start a flight.
REQ-009 The module SHALL have port launch_x, input, 10 bits: initial posx.
REQ-010 The module SHALL have port launch_vx, input, 6 bits signed: horizontal velocity in px/frame.
REQ-011 The module SHALL have port launch_vy, input, 7 bits signed: initial vertical velocity in px/frame; negative means upward.
REQ-012 The module SHALL have port sliced, input, 1 bit: the object was hit by the blade.
REQ-013 The module SHALL have port out_of_bound, input, 1 bit: the registered flag from the downstream bound checker.
REQ-014 The module SHALL have port posx, output, 10 bits: object x, modulo 1024.
REQ-015 The module SHALL have port posy, output, 9 bits: object y, modulo 512.
REQ-016 The module SHALL have port active, output, 1 bit: high while in state FLY.
REQ-017 The module SHALL have port missed, output, 1 bit: one-cycle pulse when the object leaves the screen unsliced.
REQ-018 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when the flight is aborted by MAX_FRAMES.

Function
REQ-019 The module SHALL implement a two-state FSM: IDLE and FLY.
REQ-020 In IDLE with launch=1, the module SHALL load posx=launch_x, posy=LAUNCH_Y, vx, vy and frame_cnt=0 next cycle and enter FLY.
REQ-021 In FLY, launch SHALL be ignored.
REQ-022 In FLY, on frame_tick the module SHALL update posx+=vx and posy+=vy using the current vy, then vy+=GRAVITY, then frame_cnt+=1, all registered in the same edge.
REQ-023 Position arithmetic SHALL sign-extend the velocity and truncate the result to 10/9 bits (wrap), so off-left/off-top positions appear as large values that the bound checker detects.
REQ-024 vy SHALL saturate at +VY_MAX; vx SHALL be constant for the whole flight.
REQ-025 out_of_bound SHALL be honoured only in FLY while vy >= 0 (falling); while rising it SHALL be ignored because the object starts below the visible area.
REQ-026 An honoured out_of_bound SHALL cause FLY->IDLE with missed=1 for one cycle.
REQ-027 sliced=1 in FLY SHALL cause FLY->IDLE with no missed pulse.
REQ-028 If sliced and an honoured out_of_bound coincide, sliced SHALL win and missed SHALL stay 0.
REQ-029 If sliced and frame_tick coincide, no position update SHALL occur.
REQ-030 When frame_cnt reaches MAX_FRAMES on a frame_tick, the module SHALL enter IDLE with timeout=1 for one cycle, unless sliced or missed fires in that cycle.
REQ-031 In IDLE, posx and posy SHALL hold their last values and frame_tick SHALL have no effect.
REQ-032 missed and timeout SHALL never be high simultaneously.

Reset
REQ-033 While rst=1, the module SHALL set state=IDLE, posx=0, posy=0, vx=0, vy=0, frame_cnt=0, active=0, missed=0, timeout=0.
REQ-034 Reset SHALL take priority over launch, frame_tick and sliced.
REQ-035 Reset asserted mid-flight SHALL abort the flight with no missed or timeout pulse.

Structure
REQ-036 The shared game package SHALL hold the window constants (640, 480), the FSM state encoding and the default GRAVITY/VY_MAX.
REQ-037 The velocity/position integrator (posx, posy, vy update with saturation) SHALL be one natural sub-module named motion_integrator; the FSM and counters SHALL stay in object_motion.

Verification
REQ-038 Launch x=100, vx=+3, vy=-12, then 1 tick: the bench SHALL check posx=103, posy=467, active=1.
REQ-039 Same launch, 12 ticks: the bench SHALL check posy=401 (apex) and vy=0; after 24 ticks, posy=467 and vy=+12.
REQ-040 Launch x=2, vx=-3, then 1 tick: the bench SHALL check posx=1023 (wrap).
REQ-041 out_of_bound=1 while vy=-5: the bench SHALL check the FSM stays in FLY; out_of_bound=1 while vy=+4: the bench SHALL check IDLE next cycle with a one-cycle missed pulse.
REQ-042 sliced and out_of_bound both asserted with vy>0: the bench SHALL check IDLE with missed=0; separately, rst mid-flight SHALL give all outputs 0 next cycle.
REQ-043 With MAX_FRAMES=8, vy=-40, and no out_of_bound: the bench SHALL check a timeout pulse on tick 8 and active=0 next cycle.
